// File: rtl/sys_cmd_ctrl.sv
// Command sequencer: decodes framed UART bytes into RF write/read and ALU operations
// and returns results byte-wise to the TX FIFO. Optional partial-frame abort: CMD_TIMEOUT_EN.
module sys_cmd_ctrl #(
   parameter int DATA_WIDTH     = 8,
   parameter int ADDR_WIDTH     = 4,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
   input  logic                    RX_D_VLD,
   output logic                    WrEn,
   output logic                    RdEn,
   output logic [ADDR_WIDTH-1:0]   Address,
   output logic [DATA_WIDTH-1:0]   WrData,
   input  logic [DATA_WIDTH-1:0]   RdData,
   input  logic                    RdData_Valid,
   output logic [3:0]              ALU_FUN,
   output logic                    ALU_EN,
   output logic                    CLK_EN,
   input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
   input  logic                    OUT_VALID,
   output logic [DATA_WIDTH-1:0]   TX_P_DATA,
   output logic                    TX_D_VLD,
   input  logic                    FIFO_FULL
);

   localparam logic [DATA_WIDTH-1:0] CMD_WR      = DATA_WIDTH'(8'hAA);
   localparam logic [DATA_WIDTH-1:0] CMD_RD      = DATA_WIDTH'(8'hBB);
   localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP  = DATA_WIDTH'(8'hCC);
   localparam logic [DATA_WIDTH-1:0] CMD_ALU_NOP = DATA_WIDTH'(8'hDD);

   typedef enum logic [3:0] {
      S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_RD_WAIT,
      S_ALU_A, S_ALU_B, S_ALU_FUN, S_ALU_WAIT, S_TX_LO, S_TX_HI
   } state_t;

   state_t                  r_state;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic [2*DATA_WIDTH-1:0] r_result;
   logic                    r_two_bytes;
   logic                    w_timeout;
   logic                    w_frame_state;

   assign w_frame_state = (r_state inside {S_WR_ADDR, S_WR_DATA, S_RD_ADDR,
                                           S_ALU_A, S_ALU_B, S_ALU_FUN});

`ifdef CMD_TIMEOUT_EN
   localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [TMR_W-1:0] r_timer;

   // Counts silent cycles inside a partially received frame only.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)                            r_timer <= '0;
      else if (RX_D_VLD || !w_frame_state) r_timer <= '0;
      else                                 r_timer <= r_timer + TMR_W'(1);
   end

   assign w_timeout = w_frame_state && !RX_D_VLD && (r_timer == TMR_W'(TIMEOUT_CYCLES - 1));
`else
   logic w_unused_timeout_cfg;
   assign w_unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
   assign w_timeout            = 1'b0;
`endif

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state     <= S_IDLE;
         r_addr      <= '0;
         r_result    <= '0;
         r_two_bytes <= 1'b0;
         WrEn        <= 1'b0;
         RdEn        <= 1'b0;
         Address     <= '0;
         WrData      <= '0;
         ALU_FUN     <= '0;
         ALU_EN      <= 1'b0;
         CLK_EN      <= 1'b0;
         TX_P_DATA   <= '0;
         TX_D_VLD    <= 1'b0;
      end else begin
         // NOTE: strobes default low every cycle so each command yields a single-cycle pulse.
         WrEn   <= 1'b0;
         RdEn   <= 1'b0;
         ALU_EN <= 1'b0;
         if (w_timeout) begin
            r_state <= S_IDLE;
         end else begin
            case (r_state)
               S_IDLE: if (RX_D_VLD) begin
                  case (RX_P_DATA)
                     CMD_WR:      r_state <= S_WR_ADDR;
                     CMD_RD:      r_state <= S_RD_ADDR;
                     CMD_ALU_OP:  r_state <= S_ALU_A;
                     CMD_ALU_NOP: r_state <= S_ALU_FUN;
                     default:     r_state <= S_IDLE;
                  endcase
               end
               S_WR_ADDR: if (RX_D_VLD) begin
                  r_addr  <= RX_P_DATA[ADDR_WIDTH-1:0];
                  r_state <= S_WR_DATA;
               end
               S_WR_DATA: if (RX_D_VLD) begin
                  WrEn    <= 1'b1;
                  Address <= r_addr;
                  WrData  <= RX_P_DATA;
                  r_state <= S_IDLE;
               end
               S_RD_ADDR: if (RX_D_VLD) begin
                  RdEn    <= 1'b1;
                  Address <= RX_P_DATA[ADDR_WIDTH-1:0];
                  r_state <= S_RD_WAIT;
               end
               S_RD_WAIT: if (RdData_Valid) begin
                  r_result    <= {{DATA_WIDTH{1'b0}}, RdData};
                  r_two_bytes <= 1'b0;
                  TX_P_DATA   <= RdData;
                  TX_D_VLD    <= 1'b1;
                  r_state     <= S_TX_LO;
               end
               S_ALU_A: if (RX_D_VLD) begin
                  WrEn    <= 1'b1;
                  Address <= ADDR_WIDTH'(0);
                  WrData  <= RX_P_DATA;
                  r_state <= S_ALU_B;
               end
               S_ALU_B: if (RX_D_VLD) begin
                  WrEn    <= 1'b1;
                  Address <= ADDR_WIDTH'(1);
                  WrData  <= RX_P_DATA;
                  r_state <= S_ALU_FUN;
               end
               S_ALU_FUN: if (RX_D_VLD) begin
                  ALU_FUN <= RX_P_DATA[3:0];
                  ALU_EN  <= 1'b1;
                  CLK_EN  <= 1'b1;
                  r_state <= S_ALU_WAIT;
               end
               S_ALU_WAIT: if (OUT_VALID) begin
                  r_result    <= ALU_OUT;
                  r_two_bytes <= 1'b1;
                  CLK_EN      <= 1'b0;
                  TX_P_DATA   <= ALU_OUT[DATA_WIDTH-1:0];
                  TX_D_VLD    <= 1'b1;
                  r_state     <= S_TX_LO;
               end
               // A byte is accepted on any cycle where the FIFO is not full.
               S_TX_LO: if (!FIFO_FULL) begin
                  if (r_two_bytes) begin
                     TX_P_DATA <= r_result[2*DATA_WIDTH-1:DATA_WIDTH];
                     r_state   <= S_TX_HI;
                  end else begin
                     TX_D_VLD  <= 1'b0;
                     r_state   <= S_IDLE;
                  end
               end
               S_TX_HI: if (!FIFO_FULL) begin
                  TX_D_VLD <= 1'b0;
                  r_state  <= S_IDLE;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Directed self-checking bench for sys_cmd_ctrl: RF write/read, ALU with and without
// operands, TX back-pressure, ignored/discarded bytes, reset mid-command, optional timeout.
`timescale 1ns/1ps
module tb_sys_cmd_ctrl;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic [7:0]  RX_P_DATA = '0;
   logic        RX_D_VLD = 1'b0;
   logic        WrEn, RdEn, ALU_EN, CLK_EN, TX_D_VLD;
   logic [3:0]  Address, ALU_FUN;
   logic [7:0]  WrData, TX_P_DATA;
   logic [7:0]  RdData = '0;
   logic        RdData_Valid = 1'b0;
   logic [15:0] ALU_OUT = '0;
   logic        OUT_VALID = 1'b0;
   logic        FIFO_FULL = 1'b0;

   int passed = 0;
   int total  = 0;

   logic [11:0] wr_log[$];
   logic [7:0]  tx_log[$];
   int          rd_cnt = 0, alu_cnt = 0, consec = 0;
   logic [3:0]  rd_addr = '0, alu_fun = '0;
   logic        alu_clk_en = 1'b0;
   logic        prev_wr = 1'b0, prev_rd = 1'b0, prev_alu = 1'b0;

   sys_cmd_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .TIMEOUT_CYCLES(64)) dut (
      .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
      .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
      .RdData(RdData), .RdData_Valid(RdData_Valid), .ALU_FUN(ALU_FUN),
      .ALU_EN(ALU_EN), .CLK_EN(CLK_EN), .ALU_OUT(ALU_OUT), .OUT_VALID(OUT_VALID),
      .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .FIFO_FULL(FIFO_FULL)
   );

   always #5 CLK = ~CLK;

   // Observes DUT outputs mid-cycle; inputs change only at posedge+1.
   always @(negedge CLK) begin
      if (WrEn) wr_log.push_back({Address, WrData});
      if (RdEn) begin rd_cnt++; rd_addr = Address; end
      if (ALU_EN) begin alu_cnt++; alu_fun = ALU_FUN; alu_clk_en = CLK_EN; end
      if (TX_D_VLD && !FIFO_FULL) tx_log.push_back(TX_P_DATA);
      if ((WrEn && prev_wr) || (RdEn && prev_rd) || (ALU_EN && prev_alu)) consec++;
      prev_wr = WrEn; prev_rd = RdEn; prev_alu = ALU_EN;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step(input int n);
      repeat (n) begin @(posedge CLK); #1; end
   endtask

   task automatic send(input logic [7:0] b);
      RX_P_DATA = b; RX_D_VLD = 1'b1;
      step(1);
      RX_D_VLD = 1'b0;
      step(1);
   endtask

   initial begin
      int bad;
      #1;
      check("reset_strobes", {WrEn, RdEn, ALU_EN, CLK_EN, TX_D_VLD}, 0);
      check("reset_data", {Address, WrData, ALU_FUN, TX_P_DATA}, 0);
      step(3);
      RST = 1'b1;
      step(2);

      // RF write
      send(8'hAA); send(8'h05); send(8'hA6); step(2);
      check("wr_count", wr_log.size(), 1);
      check("wr_addr_data", wr_log[0], 12'h5A6);
      check("wr_no_tx", tx_log.size(), 0);

      // RF read
      send(8'hBB); send(8'h05);
      RdData = 8'hA6; RdData_Valid = 1'b1; step(1); RdData_Valid = 1'b0;
      step(4);
      check("rd_count", rd_cnt, 1);
      check("rd_addr", rd_addr, 4'h5);
      check("rd_tx_count", tx_log.size(), 1);
      check("rd_tx_byte", tx_log[0], 8'hA6);

      // ALU with operands
      send(8'hCC); send(8'h0A); send(8'h03); send(8'h00);
      check("alu_clk_en_wait", CLK_EN, 1'b1);
      ALU_OUT = 16'h000D; OUT_VALID = 1'b1; step(1); OUT_VALID = 1'b0;
      check("alu_clk_en_drop", CLK_EN, 1'b0);
      step(4);
      check("alu_wr_count", wr_log.size(), 3);
      check("alu_wr_a", wr_log[1], 12'h00A);
      check("alu_wr_b", wr_log[2], 12'h103);
      check("alu_en_count", alu_cnt, 1);
      check("alu_fun", alu_fun, 4'h0);
      check("alu_clk_en_at_start", alu_clk_en, 1'b1);
      check("alu_tx_count", tx_log.size(), 3);
      check("alu_tx_lo", tx_log[1], 8'h0D);
      check("alu_tx_hi", tx_log[2], 8'h00);

      // ALU without operands, TX back-pressure, byte discarded in TX_LO
      send(8'hDD); send(8'h02);
      FIFO_FULL = 1'b1;
      ALU_OUT = 16'h1234; OUT_VALID = 1'b1; step(1); OUT_VALID = 1'b0;
      send(8'hAA);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (!(TX_D_VLD === 1'b1 && TX_P_DATA === 8'h34)) bad++;
         step(1);
      end
      check("stall_hold", bad, 0);
      check("stall_no_accept", tx_log.size(), 3);
      FIFO_FULL = 1'b0;
      step(4);
      check("stall_tx_count", tx_log.size(), 5);
      check("stall_tx_lo", tx_log[3], 8'h34);
      check("stall_tx_hi", tx_log[4], 8'h12);
      check("stall_tx_idle", TX_D_VLD, 1'b0);
      check("nop_alu_fun", alu_fun, 4'h2);

      // Unknown byte ignored in IDLE
      send(8'h55); send(8'hAA); send(8'h03); send(8'h7F); step(2);
      check("ign_wr_count", wr_log.size(), 4);
      check("ign_wr", wr_log[3], 12'h37F);

      // Reset with a pending TX byte, then mid-frame
      send(8'hBB); send(8'h04);
      FIFO_FULL = 1'b1;
      RdData = 8'h5C; RdData_Valid = 1'b1; step(1); RdData_Valid = 1'b0;
      step(2);
      check("rst_pending_tx", {TX_D_VLD, TX_P_DATA}, 9'h15C);
      RST = 1'b0; #1;
      check("rst_clear", {TX_D_VLD, WrEn, RdEn, ALU_EN, CLK_EN, Address}, 0);
      step(1); RST = 1'b1; FIFO_FULL = 1'b0;
      step(3);
      check("rst_tx_dropped", tx_log.size(), 5);
      send(8'hAA); send(8'h07);
      RST = 1'b0; step(1); RST = 1'b1; step(1);
      send(8'hAA); send(8'h02); send(8'h33); step(2);
      check("rst_frame_count", wr_log.size(), 5);
      check("rst_frame_wr", wr_log[4], 12'h233);
      check("rd_count_final", rd_cnt, 2);

`ifdef CMD_TIMEOUT_EN
      send(8'hAA); send(8'h05);
      step(64);
      check("to_no_wr", wr_log.size(), 5);
      send(8'hAA); send(8'h01); send(8'h11); step(2);
      check("to_wr_count", wr_log.size(), 6);
      check("to_wr", wr_log[5], 12'h111);
`endif

      check("alu_count_final", alu_cnt, 2);
      check("no_consecutive_strobes", consec, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
